// File: rtl/spike_rate_meter.sv
// spike_rate_meter: windowed spike rate, inter-spike interval and burst flag
// for the lif neuron; all state advances only on en strobes.
module spike_rate_meter #(
    parameter int WIN_TICKS = 16,
    parameter int CNT_W     = 8,
    parameter int ISI_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike,
    input  logic [CNT_W-1:0] thresh,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid,
    output logic             burst
);
    localparam int TW = $clog2(WIN_TICKS);
    localparam logic [TW-1:0] LAST = TW'(WIN_TICKS - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [ISI_W-1:0] IMAX = '1;

    typedef enum logic {IDLE, ARMED} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [CNT_W-1:0] scnt_q, scnt_d, scnt_ev;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic [ISI_W-1:0] since_q, since_d;
    logic [ISI_W-1:0] isi_q, isi_d;
    logic             rate_valid_q, rate_valid_d;
    logic             isi_valid_q, isi_valid_d;
    logic             burst_q, burst_d;
    logic             ev, close;

    always_comb begin
        ev           = en & spike;
        close        = en && (tick_q == LAST);
        tick_d       = !en ? tick_q : close ? '0 : tick_q + 1'b1;
        // the closing strobe's own event still belongs to the closing window
        scnt_ev      = (ev && scnt_q != CMAX) ? scnt_q + 1'b1 : scnt_q;
        scnt_d       = close ? '0 : scnt_ev;
        rate_d       = close ? scnt_ev : rate_q;
        burst_d      = close ? (scnt_ev >= thresh) : burst_q;
        rate_valid_d = close;
        state_d      = ev ? ARMED : state_q;
        isi_valid_d  = ev && state_q == ARMED;
        isi_d        = isi_valid_d ? since_q : isi_q;
        since_d      = ev ? ISI_W'(1)
                     : (en && state_q == ARMED && since_q != IMAX) ? since_q + 1'b1
                     : since_q;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            scnt_q       <= '0;
            rate_q       <= '0;
            since_q      <= '0;
            isi_q        <= '0;
            rate_valid_q <= 1'b0;
            isi_valid_q  <= 1'b0;
            burst_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            scnt_q       <= scnt_d;
            rate_q       <= rate_d;
            since_q      <= since_d;
            isi_q        <= isi_d;
            rate_valid_q <= rate_valid_d;
            isi_valid_q  <= isi_valid_d;
            burst_q      <= burst_d;
        end
    end

    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;
    assign isi        = isi_q;
    assign isi_valid  = isi_valid_q;
    assign burst      = burst_q;
endmodule

// File: tb/tb_spike_rate_meter.sv
// tb_spike_rate_meter: directed table vectors plus hand sequences; a second
// instance with narrow counters exercises saturation.
module tb_spike_rate_meter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       spike = 1'b0;
    logic [7:0] thresh = 8'd10;
    logic [7:0] rate, isi;
    logic       rate_valid, isi_valid, burst;
    logic [3:0] s_rate, s_isi;
    logic       s_rate_valid, s_isi_valid, s_burst;

    int vectors = 0;
    int miscompares = 0;

    spike_rate_meter dut (
        .clk(clk), .rst_n(rst_n), .en(en), .spike(spike), .thresh(thresh),
        .rate(rate), .rate_valid(rate_valid), .isi(isi), .isi_valid(isi_valid), .burst(burst)
    );

    spike_rate_meter #(.WIN_TICKS(32), .CNT_W(4), .ISI_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .spike(spike), .thresh(thresh[3:0]),
        .rate(s_rate), .rate_valid(s_rate_valid), .isi(s_isi), .isi_valid(s_isi_valid), .burst(s_burst)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rst, en, spike, thresh, reps;
        int rate, rv, isi, iv, burst;
    } vec_t;

    vec_t tbl[14];

    task automatic step(input logic r, input logic e, input logic s);
        rst_n = r;
        en    = e;
        spike = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int rv_n, rv_at, iv_n, isi_seen;

    initial begin
        // rst en sp th reps | rate rv isi iv burst
        tbl[0]  = '{1, 1, 1, 10, 2,  0,  0, 0,  0, 0};
        tbl[1]  = '{0, 1, 1, 10, 1,  0,  0, 0,  0, 0};
        tbl[2]  = '{0, 1, 1, 10, 1,  0,  0, 1,  1, 0};
        tbl[3]  = '{0, 1, 1, 10, 13, 0,  0, 1,  1, 0};
        tbl[4]  = '{0, 1, 1, 10, 1,  16, 1, 1,  1, 1};
        tbl[5]  = '{0, 1, 1, 10, 1,  16, 0, 1,  1, 1};
        tbl[6]  = '{0, 1, 1, 10, 15, 16, 1, 1,  1, 1};
        tbl[7]  = '{0, 0, 1, 10, 50, 16, 0, 1,  0, 1};
        tbl[8]  = '{0, 1, 0, 10, 1,  16, 0, 1,  0, 1};
        tbl[9]  = '{0, 1, 0, 0,  15, 0,  1, 1,  0, 1};
        tbl[10] = '{0, 1, 1, 0,  1,  0,  0, 17, 1, 1};
        tbl[11] = '{0, 1, 0, 1,  14, 0,  0, 17, 0, 1};
        tbl[12] = '{0, 1, 1, 1,  1,  2,  1, 15, 1, 1};
        tbl[13] = '{0, 1, 0, 1,  1,  2,  0, 15, 0, 1};

        for (int i = 0; i < 14; i++) begin
            thresh = 8'(tbl[i].thresh);
            repeat (tbl[i].reps) step(tbl[i].rst[0], tbl[i].en[0], tbl[i].spike[0]);
            vectors++;
            if (int'(rate) != tbl[i].rate || int'(rate_valid) != tbl[i].rv ||
                int'(isi) != tbl[i].isi || int'(isi_valid) != tbl[i].iv ||
                int'(burst) != tbl[i].burst) begin
                miscompares++;
                $display("FAIL vec%0d: got rate=%0d rv=%0d isi=%0d iv=%0d burst=%0d expected rate=%0d rv=%0d isi=%0d iv=%0d burst=%0d",
                         i, rate, rate_valid, isi, isi_valid, burst,
                         tbl[i].rate, tbl[i].rv, tbl[i].isi, tbl[i].iv, tbl[i].burst);
            end
        end

        // reset with en/spike high, then 20 quiet strobes
        thresh = 8'd10;
        step(1, 1, 1);
        step(1, 1, 1);
        chk("rst_outputs", int'({rate, rate_valid, isi, isi_valid, burst}), 0);
        rv_n = 0; rv_at = 0; iv_n = 0;
        for (int k = 1; k <= 20; k++) begin
            step(0, 1, 0);
            if (rate_valid) begin rv_n++; rv_at = k; end
            if (isi_valid) iv_n++;
        end
        chk("quiet_rv_count", rv_n, 1);
        chk("quiet_rv_at", rv_at, 16);
        chk("quiet_rate", int'(rate), 0);
        chk("quiet_iv_count", iv_n, 0);

        // sparse strobes: en every 4th cycle, spikes on strobes 3 and 10
        thresh = 8'd3;
        step(1, 0, 0);
        rv_n = 0; iv_n = 0; isi_seen = 0;
        for (int k = 1; k <= 16; k++) begin
            repeat (3) step(0, 0, 0);
            step(0, 1, (k == 3 || k == 10));
            if (isi_valid) begin iv_n++; isi_seen = int'(isi); end
            if (rate_valid) rv_n++;
            if (k == 16) begin
                chk("sparse_close_rv", int'(rate_valid), 1);
                chk("sparse_rate", int'(rate), 2);
                chk("sparse_burst", int'(burst), 0);
            end
        end
        chk("sparse_iv_count", iv_n, 1);
        chk("sparse_isi", isi_seen, 7);
        chk("sparse_rv_count", rv_n, 1);

        // saturation on the narrow instance
        thresh = 8'd10;
        step(1, 1, 1);
        for (int k = 1; k <= 32; k++) step(0, 1, 1);
        chk("sat_rv", int'(s_rate_valid), 1);
        chk("sat_rate", int'(s_rate), 15);
        chk("sat_burst", int'(s_burst), 1);
        chk("wide_rate", int'(rate), 16);
        repeat (19) step(0, 1, 0);
        step(0, 1, 1);
        chk("sat_isi_valid", int'(s_isi_valid), 1);
        chk("sat_isi", int'(s_isi), 15);
        chk("wide_isi", int'(isi), 20);

        // reset mid-window after 5 spikes
        step(1, 0, 0);
        for (int k = 1; k <= 8; k++) step(0, 1, (k <= 5));
        chk("mid_pre_isi", int'(isi), 1);
        step(1, 1, 1);
        chk("mid_rst_outputs", int'({rate, rate_valid, isi, isi_valid, burst}), 0);
        iv_n = 0; isi_seen = 0;
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, (k == 2 || k == 5 || k == 9));
            if (isi_valid) begin
                iv_n++;
                if (iv_n == 1) isi_seen = int'(isi);
            end
            if (k == 2) chk("mid_first_no_iv", int'(isi_valid), 0);
            if (k == 16) begin
                chk("mid_close_rv", int'(rate_valid), 1);
                chk("mid_rate", int'(rate), 3);
            end
        end
        chk("mid_iv_count", iv_n, 2);
        chk("mid_first_isi", isi_seen, 3);
        chk("mid_last_isi", int'(isi), 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
